gemm_result_unloader: RTL and testbench

//  Result-side counterpart of the operand loader. Reads one NUM_ROW x NUM_COL output tile from the

---
 rtl/gemm_result_unloader_pkg.sv | 7 +
 rtl/gemm_result_unloader_tile_buffer.sv | 26 ++
 rtl/gemm_result_unloader.sv | 112 +++++++++++
 tb/tb_gemm_result_unloader.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/gemm_result_unloader_pkg.sv
// gemm_result_unloader_pkg: shared FSM state encoding and index width helper
package gemm_result_unloader_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_READ, ST_WAIT, ST_EMIT, ST_DONE} state_e;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/gemm_result_unloader_tile_buffer.sv
// gemm_result_unloader_tile_buffer: NUM_ROW row registers with a row write port and combinational word read
module gemm_result_unloader_tile_buffer
  import gemm_result_unloader_pkg::*;
#(
  parameter int NUM_ROW = 4,
  parameter int NUM_COL = 4,
  parameter int W = 32,
  localparam int RW = idx_w(NUM_ROW),
  localparam int CW = idx_w(NUM_COL)
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [RW-1:0]        i_wrow,
  input  logic [NUM_COL*W-1:0] i_wdata,
  input  logic [RW-1:0]        i_rrow,
  input  logic [CW-1:0]        i_rcol,
  output logic [W-1:0]         o_rdata
);
  logic [NUM_COL*W-1:0] rows_q [NUM_ROW];
  logic [NUM_COL*W-1:0] row;
  always_ff @(posedge clk) begin
    if (i_we) rows_q[i_wrow] <= i_wdata;
  end
  assign row = rows_q[i_rrow];
  assign o_rdata = row[i_rcol*W +: W];
endmodule

// File: rtl/gemm_result_unloader.sv
// gemm_result_unloader: reads one output tile from the down SRAM and streams it column-major over valid/ready
module gemm_result_unloader
  import gemm_result_unloader_pkg::*;
#(
  parameter int NUM_ROW = 4,
  parameter int NUM_COL = 4,
  parameter int OUT_DATA_WIDTH = 32,
  parameter int LOG2_SRAM_BANK_DEPTH = 5,
  parameter int RD_LATENCY = 1,
  localparam int KW = idx_w(NUM_ROW*NUM_COL)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              i_start,
  input  logic [LOG2_SRAM_BANK_DEPTH-1:0]   i_start_addr,
  output logic                              o_busy,
  output logic                              o_done,
  output logic                              o_down_rd_en,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0]   o_down_rd_addr,
  input  logic [NUM_COL*OUT_DATA_WIDTH-1:0] i_down_rd_data,
  output logic [OUT_DATA_WIDTH-1:0]         o_data,
  output logic                              o_valid,
  input  logic                              i_ready,
  output logic [KW-1:0]                     o_index,
  output logic                              o_last
);
  localparam int RW = idx_w(NUM_ROW);
  localparam int CW = idx_w(NUM_COL);
  localparam int AW = LOG2_SRAM_BANK_DEPTH;
  localparam int L = RD_LATENCY;
  localparam int N = NUM_ROW * NUM_COL;
  state_e state_q, state_d;
  logic [RW-1:0] rc_q, rc_d;
  logic [KW-1:0] k_q, k_d;
  logic [AW-1:0] base_q, base_d;
  logic [L-1:0] pv_q, pv_d;
  logic [RW-1:0] pr_q [L];
  logic [RW-1:0] pr_d [L];
  logic cap, emit, last_beat;
  logic [OUT_DATA_WIDTH-1:0] word;
  assign cap = pv_q[L-1];
  assign emit = state_q == ST_EMIT;
  assign last_beat = k_q == KW'(N-1);
  always_comb begin
    state_d = state_q;
    rc_d = rc_q;
    k_d = k_q;
    base_d = base_q;
    pv_d[0] = state_q == ST_READ;
    pr_d[0] = rc_q;
    for (int i = 1; i < L; i++) begin
      pv_d[i] = pv_q[i-1];
      pr_d[i] = pr_q[i-1];
    end
    case (state_q)
      ST_IDLE: if (i_start) begin
        state_d = ST_READ;
        rc_d = '0;
        k_d = '0;
        base_d = i_start_addr;
      end
      ST_READ: begin
        rc_d = rc_q + 1'b1;
        state_d = rc_q == RW'(NUM_ROW-1) ? ST_WAIT : ST_READ;
      end
      ST_WAIT: state_d = cap && pr_q[L-1] == RW'(NUM_ROW-1) ? ST_EMIT : ST_WAIT;
      ST_EMIT: if (i_ready) begin
        k_d = k_q + 1'b1;
        state_d = last_beat ? ST_DONE : ST_EMIT;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rc_q <= '0;
      k_q <= '0;
      base_q <= '0;
      pv_q <= '0;
      for (int i = 0; i < L; i++) pr_q[i] <= '0;
    end else begin
      state_q <= state_d;
      rc_q <= rc_d;
      k_q <= k_d;
      base_q <= base_d;
      pv_q <= pv_d;
      pr_q <= pr_d;
    end
  end
  gemm_result_unloader_tile_buffer #(
    .NUM_ROW(NUM_ROW),
    .NUM_COL(NUM_COL),
    .W(OUT_DATA_WIDTH)
  ) u_tile (
    .clk(clk),
    .i_we(cap),
    .i_wrow(pr_q[L-1]),
    .i_wdata(i_down_rd_data),
    .i_rrow(RW'(k_q % NUM_ROW)),
    .i_rcol(CW'(k_q / NUM_ROW)),
    .o_rdata(word)
  );
  assign o_busy = state_q != ST_IDLE;
  assign o_done = state_q == ST_DONE;
  assign o_down_rd_en = state_q == ST_READ;
  assign o_down_rd_addr = o_down_rd_en ? base_q + AW'(rc_q) : '0;
  assign o_valid = emit;
  assign o_data = emit ? word : '0;
  assign o_index = emit ? k_q : '0;
  assign o_last = emit && last_beat;
endmodule

// File: tb/tb_gemm_result_unloader.sv
// tb_gemm_result_unloader: scoreboard bench for the tile unloader against an SRAM model
module tb_gemm_result_unloader;
  localparam int NR = 4;
  localparam int NC = 4;
  localparam int W = 32;
  localparam int AW = 5;
  localparam int N = NR * NC;
  typedef struct packed {logic [W-1:0] d; logic [3:0] i; logic l;} beat_t;
  logic clk = 0;
  logic rst_n = 0;
  logic i_start = 0;
  logic i_ready = 0;
  logic [AW-1:0] i_start_addr = '0;
  logic o_busy, o_done, o_down_rd_en, o_valid, o_last;
  logic [AW-1:0] o_down_rd_addr;
  logic [W-1:0] o_data;
  logic [3:0] o_index;
  logic [NC*W-1:0] rd_data = '0;
  logic [NC*W-1:0] mem [32];
  beat_t exp_q[$];
  beat_t obs_q[$];
  logic [AW-1:0] rd_q[$];
  int rd_cyc_q[$];
  int checks = 0, passed = 0;
  int done_cnt, done_cyc, unstable, overlap;
  always #5 clk = ~clk;
  always @(posedge clk) if (o_down_rd_en) rd_data <= mem[o_down_rd_addr];
  gemm_result_unloader #(
    .NUM_ROW(NR), .NUM_COL(NC), .OUT_DATA_WIDTH(W), .LOG2_SRAM_BANK_DEPTH(AW), .RD_LATENCY(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_start_addr(i_start_addr),
    .o_busy(o_busy), .o_done(o_done), .o_down_rd_en(o_down_rd_en), .o_down_rd_addr(o_down_rd_addr),
    .i_down_rd_data(rd_data), .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
    .o_index(o_index), .o_last(o_last)
  );
  task automatic fill_default();
    for (int a = 0; a < 32; a++)
      for (int j = 0; j < NC; j++) mem[a][j*W +: W] = 32'h A000_0000 + 32'(a*16 + j);
  endtask
  task automatic push_tile(input logic [AW-1:0] base);
    for (int k = 0; k < N; k++) begin
      beat_t b;
      logic [AW-1:0] a;
      a = base + AW'(k % NR);
      b.d = mem[a][(k/NR)*W +: W];
      b.i = 4'(k);
      b.l = k == N-1;
      exp_q.push_back(b);
    end
  endtask
  task automatic collect(input logic [AW-1:0] base, input int pct, input int restart_at, input int budget);
    beat_t held_v, cur;
    bit held;
    held = 0;
    obs_q.delete(); rd_q.delete(); rd_cyc_q.delete();
    done_cnt = 0; done_cyc = -1; unstable = 0; overlap = 0;
    i_start = 1;
    i_start_addr = base;
    for (int n = 1; n <= budget; n++) begin
      @(posedge clk); #1;
      i_start = n == restart_at;
      if (n == restart_at) i_start_addr = base + 5'd7;
      cur = {o_data, o_index, o_last};
      if (o_down_rd_en) begin rd_q.push_back(o_down_rd_addr); rd_cyc_q.push_back(n); end
      if (o_done) begin done_cnt++; done_cyc = n; end
      if (o_done && o_valid) overlap++;
      if (held && (!o_valid || cur !== held_v)) unstable++;
      i_ready = $urandom_range(99) < pct;
      held = o_valid && !i_ready;
      held_v = cur;
      if (o_valid && i_ready) obs_q.push_back(cur);
    end
    i_start = 0;
  endtask
  task automatic test_reset();
    rst_n = 0;
    repeat (2) begin @(posedge clk); #1; i_ready = ~i_ready; end
    checks++;
    if ({o_busy, o_done, o_down_rd_en, o_down_rd_addr, o_data, o_valid, o_index, o_last} !== '0)
      $display("FAIL reset outputs: got busy=%b done=%b rd=%b addr=%0d data=%h valid=%b idx=%0d last=%b want all 0",
               o_busy, o_done, o_down_rd_en, o_down_rd_addr, o_data, o_valid, o_index, o_last);
    else passed++;
    rst_n = 1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      i_ready = ~i_ready;
      checks++;
      if ({o_busy, o_done, o_down_rd_en, o_valid, o_last} !== '0)
        $display("FAIL idle cycle %0d: got busy=%b done=%b rd=%b valid=%b last=%b want all 0",
                 c, o_busy, o_done, o_down_rd_en, o_valid, o_last);
      else passed++;
    end
  endtask
  task automatic test_basic();
    fill_default();
    for (int r = 0; r < NR; r++)
      for (int j = 0; j < NC; j++) mem[1+r][j*W +: W] = 32'(10*r + j);
    push_tile(5'd1);
    collect(5'd1, 100, 0, 30);
    checks++;
    if (rd_q.size() != NR) $display("FAIL basic read count: got %0d want %0d", rd_q.size(), NR);
    else passed++;
    for (int n = 0; n < rd_q.size() && n < NR; n++) begin
      checks++;
      if (rd_q[n] !== AW'(1 + n) || rd_cyc_q[n] != n + 1)
        $display("FAIL basic read %0d: got addr %0d cycle %0d want addr %0d cycle %0d", n, rd_q[n], rd_cyc_q[n], 1 + n, n + 1);
      else passed++;
    end
    checks++;
    if (obs_q.size() != exp_q.size()) $display("FAIL basic beat count: got %0d want %0d", obs_q.size(), exp_q.size());
    else passed++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      beat_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) $display("FAIL basic beat: got data=%h idx=%0d last=%b want data=%h idx=%0d last=%b", o.d, o.i, o.l, e.d, e.i, e.l);
      else passed++;
    end
    checks++;
    if (done_cnt != 1 || done_cyc != NR + 1 + N + 1 || overlap != 0)
      $display("FAIL basic done: got count %0d cycle %0d overlap %0d want 1 %0d 0", done_cnt, done_cyc, NR + 1 + N + 1, overlap);
    else passed++;
    exp_q.delete();
  endtask
  task automatic test_backpressure();
    push_tile(5'd1);
    collect(5'd1, 50, 0, 120);
    checks++;
    if (obs_q.size() != exp_q.size()) $display("FAIL bp beat count: got %0d want %0d", obs_q.size(), exp_q.size());
    else passed++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      beat_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) $display("FAIL bp beat: got data=%h idx=%0d last=%b want data=%h idx=%0d last=%b", o.d, o.i, o.l, e.d, e.i, e.l);
      else passed++;
    end
    checks++;
    if (unstable != 0 || done_cnt != 1 || overlap != 0)
      $display("FAIL bp stall: got unstable %0d done %0d overlap %0d want 0 1 0", unstable, done_cnt, overlap);
    else passed++;
    exp_q.delete();
  endtask
  task automatic test_wrap();
    fill_default();
    push_tile(5'd30);
    collect(5'd30, 100, 0, 30);
    checks++;
    if (rd_q.size() != NR) $display("FAIL wrap read count: got %0d want %0d", rd_q.size(), NR);
    else passed++;
    for (int n = 0; n < rd_q.size() && n < NR; n++) begin
      checks++;
      if (rd_q[n] !== AW'(30 + n)) $display("FAIL wrap read %0d: got addr %0d want %0d", n, rd_q[n], (30 + n) % 32);
      else passed++;
    end
    checks++;
    if (obs_q.size() != exp_q.size()) $display("FAIL wrap beat count: got %0d want %0d", obs_q.size(), exp_q.size());
    else passed++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      beat_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) $display("FAIL wrap beat: got data=%h idx=%0d last=%b want data=%h idx=%0d last=%b", o.d, o.i, o.l, e.d, e.i, e.l);
      else passed++;
    end
    exp_q.delete();
  endtask
  task automatic test_start_ignored();
    push_tile(5'd2);
    collect(5'd2, 100, 10, 40);
    checks++;
    if (rd_q.size() != NR || done_cnt != 1)
      $display("FAIL busy start: got reads %0d dones %0d want %0d 1", rd_q.size(), done_cnt, NR);
    else passed++;
    checks++;
    if (obs_q.size() != exp_q.size()) $display("FAIL busy start beat count: got %0d want %0d", obs_q.size(), exp_q.size());
    else passed++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      beat_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) $display("FAIL busy start beat: got data=%h idx=%0d want data=%h idx=%0d", o.d, o.i, e.d, e.i);
      else passed++;
    end
    exp_q.delete();
  endtask
  task automatic test_abort();
    bit found;
    found = 0;
    i_ready = 1;
    i_start = 1;
    i_start_addr = 5'd5;
    for (int n = 0; n < 30 && !found; n++) begin
      @(posedge clk); #1;
      i_start = 0;
      found = o_valid && o_index == 4'd5;
    end
    checks++;
    if (!found) $display("FAIL abort reach beat 5: got not seen want seen");
    else passed++;
    rst_n = 0;
    @(posedge clk); #1;
    checks++;
    if ({o_valid, o_busy, o_done, o_down_rd_en} !== 4'b0)
      $display("FAIL abort outputs: got valid=%b busy=%b done=%b rd=%b want 0", o_valid, o_busy, o_done, o_down_rd_en);
    else passed++;
    rst_n = 1;
    @(posedge clk); #1;
    push_tile(5'd3);
    collect(5'd3, 100, 0, 30);
    checks++;
    if (obs_q.size() != exp_q.size() || done_cnt != 1)
      $display("FAIL abort restart: got beats %0d dones %0d want %0d 1", obs_q.size(), done_cnt, exp_q.size());
    else passed++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      beat_t e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) $display("FAIL abort restart beat: got data=%h idx=%0d want data=%h idx=%0d", o.d, o.i, e.d, e.i);
      else passed++;
    end
    exp_q.delete();
  endtask
  initial begin
    fill_default();
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_start_ignored();
    test_abort();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
